// File: rtl/s2mm_ring_writer.sv
// AXI4-Stream to AXI3 write master: buffers stream words in a FIFO and writes
// them as fixed-length INCR bursts into a circular buffer at base + offset.
module s2mm_ring_writer #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable,
  input  logic [AXI_ADDR_WIDTH-1:0]     base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]     buffer_size,
  output logic [AXI_ADDR_WIDTH-1:0]     write_offset,
  output logic [15:0]                   wrap_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          bresp_err,
  output logic                          busy,
  output logic                          S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  output logic [AXI_ID_WIDTH-1:0]       M_AXI_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_awaddr,
  output logic [3:0]                    M_AXI_awlen,
  output logic [2:0]                    M_AXI_awsize,
  output logic [1:0]                    M_AXI_awburst,
  output logic [3:0]                    M_AXI_awcache,
  output logic [2:0]                    M_AXI_awprot,
  output logic                          M_AXI_awuser,
  output logic                          M_AXI_awvalid,
  input  logic                          M_AXI_awready,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_wstrb,
  output logic                          M_AXI_wlast,
  output logic                          M_AXI_wvalid,
  input  logic                          M_AXI_wready,
  input  logic [1:0]                    M_AXI_bresp,
  input  logic                          M_AXI_bvalid,
  output logic                          M_AXI_bready
);

  localparam int BURST_BYTES = BURST_LEN * AXI_DATA_WIDTH / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0]               LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [LW-1:0]            BURST_LVL = LW'(BURST_LEN);
  localparam logic [LW-1:0]            DEPTH_LVL = LW'(FIFO_DEPTH);
  localparam logic [AXI_ADDR_WIDTH:0]  OFF_STEP  = (AXI_ADDR_WIDTH + 1)'(BURST_BYTES);

  // FIFO: distributed array with first-word fall-through read of the head
  logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          tready_q;
  logic          push, pop;

  logic [1:0]                state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                      wvalid_q, wvalid_d;
  logic                      wlast_q, wlast_d;
  logic                      bready_q, bready_d;
  logic [3:0]                beat_q, beat_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [AXI_ADDR_WIDTH-1:0] size_q, size_d;
  logic [AXI_ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [15:0]               wrap_q, wrap_d;
  logic                      err_q, err_d;
  logic [AXI_ADDR_WIDTH:0]   next_off;

  assign push    = S_AXIS_tvalid && tready_q;
  assign pop     = wvalid_q && M_AXI_wready;
  assign level_d = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= S_AXIS_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q  <= level_d;
      tready_q <= (level_d != DEPTH_LVL);
    end
  end

  // Offset sum carries one extra bit so a ring ending at the top of memory compares correctly
  assign next_off = {1'b0, offset_q} + OFF_STEP;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    beat_d    = beat_q;
    base_d    = base_q;
    size_d    = size_q;
    offset_d  = offset_q;
    wrap_d    = wrap_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (!enable) begin
          base_d   = base_addr;
          size_d   = buffer_size;
          offset_d = '0;
        end else if (level_q >= BURST_LVL) begin
          awvalid_d = 1'b1;
          awaddr_d  = base_q + offset_q;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (M_AXI_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = (LAST_BEAT == 4'd0);
          beat_d    = 4'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (M_AXI_wready) begin
          if (beat_q == LAST_BEAT) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = S_RESP;
          end else begin
            beat_d  = beat_q + 4'd1;
            wlast_d = ((beat_q + 4'd1) == LAST_BEAT);
          end
        end
      end
      default: begin
        if (M_AXI_bvalid) begin
          bready_d = 1'b0;
          state_d  = S_IDLE;
          if (M_AXI_bresp != 2'b00) err_d = 1'b1;
          if (next_off >= {1'b0, size_q}) begin
            offset_d = '0;
            wrap_d   = wrap_q + 16'd1;
          end else begin
            offset_d = next_off[AXI_ADDR_WIDTH-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      beat_q    <= 4'd0;
      base_q    <= '0;
      size_q    <= '0;
      offset_q  <= '0;
      wrap_q    <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      size_q    <= size_d;
      offset_q  <= offset_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  assign write_offset  = offset_q;
  assign wrap_count    = wrap_q;
  assign fifo_level    = level_q;
  assign bresp_err     = err_q;
  assign busy          = (state_q != S_IDLE);
  assign S_AXIS_tready = tready_q;

  assign M_AXI_awid    = '0;
  assign M_AXI_awaddr  = awaddr_q;
  assign M_AXI_awlen   = LAST_BEAT;
  assign M_AXI_awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign M_AXI_awburst = 2'b01;
  assign M_AXI_awcache = 4'b0011;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_awuser  = 1'b0;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = mem_q[rd_ptr_q];
  assign M_AXI_wstrb   = '1;
  assign M_AXI_wlast   = wlast_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;

endmodule

// File: tb/tb_s2mm_ring_writer.sv
// Directed bench for s2mm_ring_writer: 32-bit data, 4-beat bursts, 16-entry FIFO,
// 64-byte ring at 0x1000_0000.
module tb_s2mm_ring_writer;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic [31:0] base_addr;
  logic [31:0] buffer_size;
  logic [31:0] write_offset;
  logic [15:0] wrap_count;
  logic [4:0]  fifo_level;
  logic        bresp_err;
  logic        busy;
  logic        S_AXIS_tready;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic [5:0]  M_AXI_awid;
  logic [31:0] M_AXI_awaddr;
  logic [3:0]  M_AXI_awlen;
  logic [2:0]  M_AXI_awsize;
  logic [1:0]  M_AXI_awburst;
  logic [3:0]  M_AXI_awcache;
  logic [2:0]  M_AXI_awprot;
  logic        M_AXI_awuser;
  logic        M_AXI_awvalid;
  logic        M_AXI_awready;
  logic [31:0] M_AXI_wdata;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_wlast;
  logic        M_AXI_wvalid;
  logic        M_AXI_wready;
  logic [1:0]  M_AXI_bresp;
  logic        M_AXI_bvalid;
  logic        M_AXI_bready;

  int total = 0;
  int bad   = 0;

  s2mm_ring_writer #(
    .AXI_ADDR_WIDTH(32),
    .AXI_ID_WIDTH  (6),
    .AXI_DATA_WIDTH(32),
    .BURST_LEN     (4),
    .FIFO_DEPTH    (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .base_addr    (base_addr),
    .buffer_size  (buffer_size),
    .write_offset (write_offset),
    .wrap_count   (wrap_count),
    .fifo_level   (fifo_level),
    .bresp_err    (bresp_err),
    .busy         (busy),
    .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata (S_AXIS_tdata),
    .S_AXIS_tvalid(S_AXIS_tvalid),
    .M_AXI_awid   (M_AXI_awid),
    .M_AXI_awaddr (M_AXI_awaddr),
    .M_AXI_awlen  (M_AXI_awlen),
    .M_AXI_awsize (M_AXI_awsize),
    .M_AXI_awburst(M_AXI_awburst),
    .M_AXI_awcache(M_AXI_awcache),
    .M_AXI_awprot (M_AXI_awprot),
    .M_AXI_awuser (M_AXI_awuser),
    .M_AXI_awvalid(M_AXI_awvalid),
    .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata  (M_AXI_wdata),
    .M_AXI_wstrb  (M_AXI_wstrb),
    .M_AXI_wlast  (M_AXI_wlast),
    .M_AXI_wvalid (M_AXI_wvalid),
    .M_AXI_wready (M_AXI_wready),
    .M_AXI_bresp  (M_AXI_bresp),
    .M_AXI_bvalid (M_AXI_bvalid),
    .M_AXI_bready (M_AXI_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Stream n consecutive words starting at value first, honouring tready
  task automatic push_words(input int n, input logic [31:0] first);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 200) begin
      @(negedge aclk);
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = first + 32'(k);
      if (S_AXIS_tready) k++;
      guard++;
    end
    @(negedge aclk);
    S_AXIS_tvalid = 1'b0;
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL push_words accepted=%0d want=%0d", k, n);
    end
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    do begin
      @(negedge aclk);
      c++;
    end while (busy && c < bound);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle busy=%b want=0 after %0d cycles", busy, c);
    end
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    aresetn = 1'b0; enable = 1'b0; base_addr = BASE; buffer_size = 32'd64;
    S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0;
    M_AXI_awready = 1'b0; M_AXI_wready = 1'b0; M_AXI_bvalid = 1'b0; M_AXI_bresp = 2'b00;
    repeat (3) @(negedge aclk);
    flags = {M_AXI_awvalid, M_AXI_wvalid, M_AXI_wlast, M_AXI_bready, S_AXIS_tready, busy, bresp_err};
    total++;
    if (flags !== 7'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000000", flags); end
    total++;
    if (write_offset !== 32'd0) begin bad++; $display("FAIL reset_offset got=%h want=0", write_offset); end
    total++;
    if (wrap_count !== 16'd0) begin bad++; $display("FAIL reset_wrap got=%0d want=0", wrap_count); end
    total++;
    if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    aresetn = 1'b1;
    #1;
    total++;
    if (S_AXIS_tready !== 1'b0) begin bad++; $display("FAIL tready_before_edge got=%b want=0", S_AXIS_tready); end
    @(negedge aclk);
    total++;
    if (S_AXIS_tready !== 1'b1) begin bad++; $display("FAIL tready_after_edge got=%b want=1", S_AXIS_tready); end
    $display("reset: flags=%b offset=%h wrap=%0d level=%0d", flags, write_offset, wrap_count, fifo_level);
  endtask

  task automatic test_stream_bursts();
    logic [31:0] aw_addr [4];
    int          aw_cyc  [4];
    int          n_aw = 0, n_w = 0, n_b = 0, pushed = 0;
    bit          chk_pending = 1'b0;
    logic        exp_last;
    M_AXI_awready = 1'b1; M_AXI_wready = 1'b1; M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b00;
    enable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (M_AXI_awvalid && M_AXI_awready) begin
        if (n_aw < 4) begin aw_addr[n_aw] = M_AXI_awaddr; aw_cyc[n_aw] = c; end
        n_aw++;
      end
      if (M_AXI_wvalid && M_AXI_wready) begin
        exp_last = (n_w % 4 == 3);
        total++;
        if (M_AXI_wdata !== 32'(n_w) || M_AXI_wlast !== exp_last) begin
          bad++;
          $display("FAIL stream_beat%0d data=%h last=%b want data=%h last=%b",
                   n_w, M_AXI_wdata, M_AXI_wlast, 32'(n_w), exp_last);
        end
        n_w++;
      end
      if (chk_pending) begin
        chk_pending = 1'b0;
        total++;
        if (write_offset !== 32'((n_b * 16) % 64) || wrap_count !== 16'((n_b == 4) ? 1 : 0)) begin
          bad++;
          $display("FAIL stream_resp%0d offset=%h wrap=%0d want offset=%h wrap=%0d", n_b,
                   write_offset, wrap_count, 32'((n_b * 16) % 64), (n_b == 4) ? 1 : 0);
        end
        $display("stream: resp %0d offset=%h wrap=%0d", n_b, write_offset, wrap_count);
      end
      if (M_AXI_bready && M_AXI_bvalid) begin
        n_b++;
        chk_pending = 1'b1;
      end
      if (pushed < 16) begin
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = 32'(pushed);
        if (S_AXIS_tready) pushed++;
      end else begin
        S_AXIS_tvalid = 1'b0;
      end
      if (n_b == 4 && !chk_pending) break;
    end
    total++;
    if (n_aw != 4 || n_w != 16 || n_b != 4) begin
      bad++;
      $display("FAIL stream_counts aw=%0d w=%0d b=%0d want 4/16/4", n_aw, n_w, n_b);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (aw_addr[k] !== BASE + 32'(16 * k)) begin
        bad++;
        $display("FAIL stream_awaddr%0d got=%h want=%h", k, aw_addr[k], BASE + 32'(16 * k));
      end
    end
    for (int k = 1; k < 4; k++) begin
      total++;
      if (aw_cyc[k] - aw_cyc[k-1] != 7) begin
        bad++;
        $display("FAIL stream_period%0d got=%0d want=7", k, aw_cyc[k] - aw_cyc[k-1]);
      end
    end
  endtask

  task automatic test_threshold();
    int early = 0;
    push_words(3, 32'h50);
    repeat (4) begin
      @(negedge aclk);
      if (M_AXI_awvalid) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL threshold_3words awvalid_cycles=%0d want=0", early); end
    @(negedge aclk);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'h53;
    @(negedge aclk);
    S_AXIS_tvalid = 1'b0;
    total++;
    if (M_AXI_awvalid !== 1'b0) begin bad++; $display("FAIL threshold_1cycle awvalid=%b want=0", M_AXI_awvalid); end
    @(negedge aclk);
    total++;
    if (M_AXI_awvalid !== 1'b1 || M_AXI_awaddr !== BASE) begin
      bad++;
      $display("FAIL threshold_2cycle awvalid=%b awaddr=%h want 1/%h", M_AXI_awvalid, M_AXI_awaddr, BASE);
    end
    $display("threshold: awvalid=%b awaddr=%h", M_AXI_awvalid, M_AXI_awaddr);
    wait_idle(50);
  endtask

  task automatic test_wready_stall();
    int beats = 0, stall = 0, after_stall = 0;
    logic exp_last;
    M_AXI_wready = 1'b1;
    push_words(4, 32'hA0);
    for (int c = 0; c < 80; c++) begin
      @(negedge aclk);
      if (beats == 2 && stall < 5) begin
        M_AXI_wready = 1'b0;
        stall++;
        total++;
        if (M_AXI_wvalid !== 1'b1 || M_AXI_wdata !== 32'hA2 || M_AXI_wlast !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold%0d wvalid=%b data=%h last=%b want 1/000000a2/0",
                   stall, M_AXI_wvalid, M_AXI_wdata, M_AXI_wlast);
        end
      end else begin
        M_AXI_wready = 1'b1;
      end
      if (M_AXI_wvalid && M_AXI_wready) begin
        exp_last = (beats == 3);
        total++;
        if (M_AXI_wdata !== 32'hA0 + 32'(beats) || M_AXI_wlast !== exp_last) begin
          bad++;
          $display("FAIL stall_beat%0d data=%h last=%b want %h/%b", beats, M_AXI_wdata,
                   M_AXI_wlast, 32'hA0 + 32'(beats), exp_last);
        end
        beats++;
        if (stall == 5) after_stall++;
      end
      if (beats == 4 && !busy) break;
    end
    M_AXI_wready = 1'b1;
    total++;
    if (beats != 4 || after_stall != 2 || stall != 5) begin
      bad++;
      $display("FAIL stall_counts beats=%0d after=%0d stalls=%0d want 4/2/5", beats, after_stall, stall);
    end
    $display("stall: beats=%0d after_stall=%0d", beats, after_stall);
  endtask

  task automatic test_fifo_full();
    int acc = 0, nb = 0;
    bit first_idle = 1'b0;
    M_AXI_awready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge aclk);
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 32'h100 + 32'(acc);
      if (S_AXIS_tready) acc++;
    end
    @(negedge aclk);
    S_AXIS_tvalid = 1'b0;
    total++;
    if (acc != 16 || S_AXIS_tready !== 1'b0 || fifo_level !== 5'd16) begin
      bad++;
      $display("FAIL full_accept acc=%0d tready=%b level=%0d want 16/0/16", acc, S_AXIS_tready, fifo_level);
    end
    total++;
    if (M_AXI_awvalid !== 1'b1 || M_AXI_awaddr !== BASE + 32'h20) begin
      bad++;
      $display("FAIL full_aw awvalid=%b awaddr=%h want 1/%h", M_AXI_awvalid, M_AXI_awaddr, BASE + 32'h20);
    end
    M_AXI_awready = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge aclk);
      if (M_AXI_wvalid && M_AXI_wready) begin
        total++;
        if (M_AXI_wdata !== 32'h100 + 32'(nb)) begin
          bad++;
          $display("FAIL full_beat%0d data=%h want=%h", nb, M_AXI_wdata, 32'h100 + 32'(nb));
        end
        nb++;
      end
      if (!busy && nb == 4 && !first_idle) begin
        first_idle = 1'b1;
        total++;
        if (fifo_level !== 5'd12) begin bad++; $display("FAIL full_level_after1 got=%0d want=12", fifo_level); end
      end
      if (nb == 16 && !busy) break;
    end
    total++;
    if (nb != 16 || wrap_count !== 16'd2 || write_offset !== 32'h20) begin
      bad++;
      $display("FAIL full_drain beats=%0d wrap=%0d offset=%h want 16/2/20", nb, wrap_count, write_offset);
    end
    $display("full: accepted=%0d beats=%0d wrap=%0d offset=%h", acc, nb, wrap_count, write_offset);
  endtask

  task automatic test_bresp_err();
    logic err_seen [3];
    int nr = 0;
    enable = 1'b0;
    push_words(12, 32'h200);
    enable = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge aclk);
      M_AXI_bresp = (nr == 1) ? 2'b10 : 2'b00;
      if (M_AXI_bready && M_AXI_bvalid) begin
        if (nr < 3) err_seen[nr] = bresp_err;
        nr++;
      end
      if (nr == 3 && !busy) break;
    end
    M_AXI_bresp = 2'b00;
    total++;
    if (nr != 3 || err_seen[0] !== 1'b0 || err_seen[1] !== 1'b0 || err_seen[2] !== 1'b1) begin
      bad++;
      $display("FAIL bresp_seq resps=%0d err=%b%b%b want 3/001", nr, err_seen[0], err_seen[1], err_seen[2]);
    end
    repeat (3) @(negedge aclk);
    total++;
    if (bresp_err !== 1'b1 || write_offset !== 32'h30) begin
      bad++;
      $display("FAIL bresp_sticky err=%b offset=%h want 1/30", bresp_err, write_offset);
    end
    $display("bresp: err=%b offset=%h", bresp_err, write_offset);
  endtask

  task automatic test_enable_drop();
    int nb = 0, seen = 0;
    bit dropped = 1'b0;
    enable = 1'b0;
    push_words(8, 32'h300);
    enable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (M_AXI_wvalid && !dropped) begin
        enable  = 1'b0;
        dropped = 1'b1;
      end
      if (M_AXI_wvalid && M_AXI_wready) nb++;
      if (dropped && !busy) break;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (M_AXI_awvalid || busy) seen++;
    end
    total++;
    if (nb != 4 || seen != 0 || fifo_level !== 5'd4 || write_offset !== 32'd0) begin
      bad++;
      $display("FAIL drop_quiesce beats=%0d activity=%0d level=%0d offset=%h want 4/0/4/0",
               nb, seen, fifo_level, write_offset);
    end
    base_addr = 32'h2000_0000;
    repeat (2) @(negedge aclk);
    enable = 1'b1;
    seen = 0;
    while (!M_AXI_awvalid && seen < 20) begin
      @(negedge aclk);
      seen++;
    end
    total++;
    if (M_AXI_awvalid !== 1'b1 || M_AXI_awaddr !== 32'h2000_0000) begin
      bad++;
      $display("FAIL drop_rebase awvalid=%b awaddr=%h want 1/20000000", M_AXI_awvalid, M_AXI_awaddr);
    end
    $display("enable_drop: beats=%0d new awaddr=%h", nb, M_AXI_awaddr);
    wait_idle(50);
  endtask

  task automatic test_reset_clear();
    push_words(2, 32'h400);
    @(negedge aclk);
    total++;
    if (fifo_level !== 5'd2 || bresp_err !== 1'b1 || wrap_count !== 16'd2) begin
      bad++;
      $display("FAIL pre_reset level=%0d err=%b wrap=%0d want 2/1/2", fifo_level, bresp_err, wrap_count);
    end
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if (fifo_level !== 5'd0 || bresp_err !== 1'b0 || wrap_count !== 16'd0 || S_AXIS_tready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset level=%0d err=%b wrap=%0d tready=%b want 0/0/0/0",
               fifo_level, bresp_err, wrap_count, S_AXIS_tready);
    end
    $display("reset_clear: level=%0d err=%b wrap=%0d", fifo_level, bresp_err, wrap_count);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    test_reset();
    test_stream_bursts();
    test_threshold();
    test_wready_stall();
    test_fifo_full();
    test_bresp_err();
    test_enable_drop();
    test_reset_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
